instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Writer-side counterpart of the control decoders. It accepts symbolic instruction requests (lw, sw, R-type ALU, beq) over a valid/ready handshake and encodes each into a 32-bit RV32I word. It then writes the words sequentially into instruction memory through a single write port. It sits between the bench/boot host and instruction memory, so the CPU's decoders can read back exactly what was encoded.

## Interface
- `ADDR_WIDTH`, 8: byte address width of instruction memory; depth = 2**(ADDR_WIDTH-2) words.
- `DATA_WIDTH`, 32: instruction word width.
- `OP_WIDTH`, 7: opcode field width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  pulse: arm the loader at `base_addr`; clears count, err, and any pending write.
- `finish`  in  1  pulse: end of program; move to DONE once the pending write drains.
- `base_addr`  in  ADDR_WIDTH  first write address; bits [1:0] ignored (forced 0).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  loader can accept a request this cycle.
- `req_kind`  in  2  00 lw, 01 sw, 10 R-type, 11 beq.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices.
- `req_funct3`  in  3  R-type funct3; ignored for other kinds.
- `req_funct7b5`  in  1  R-type funct7 bit 5.
- `req_imm`  in  13  signed immediate; I/S use bits [11:0], B uses [12:1].
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  write byte address.
- `mem_wdata`  out  DATA_WIDTH  encoded instruction.
- `count`  out  ADDR_WIDTH-1  words written since `start`.
- `full`  out  1  all words from `base_addr` to top of memory written.
- `err`  out  1  sticky: at least one request rejected since `start`.
- `done`  out  1  in DONE state.

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Reset → IDLE.
- `start` in any state → LOAD: ptr = {base_addr[ADDR_WIDTH-1:2],2'b00}, count = 0, err = 0, pending write cancelled. `start` has priority over `finish` and `req_valid` in the same cycle.
- LOAD: `req_ready` = !full && !finish. Accept on `req_valid && req_ready`.
- Encoding:
  - lw: {imm[11:0], rs1, 010, rd, 0000011}.
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - R-type: {0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011}.
  - beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
- Legality checks:
  - lw/sw: require imm[12]==imm[11].
  - beq: require imm[0]==0.
  - R-type with funct7b5=1: require funct3 ∈ {000, 101}.
- A rejected request is still handshaken: it is consumed, no write occurs, err is set, and ptr/count are unchanged.
- Accepted legal request: next cycle `mem_we`=1, `mem_addr`=ptr, `mem_wdata`=word. ptr += 4 and count += 1 on that write.
- `full` asserts on the write to the last address (ptr = 2**ADDR_WIDTH-4). Ptr never wraps. While full, `req_ready`=0 and the state stays LOAD.
- `finish` in LOAD → DRAIN if a write is pending, else DONE. DRAIN → DONE after one cycle. DONE holds until `start` or `rst`.
- IDLE/DONE: `req_ready`=0, `mem_we`=0.

## Timing
- Reset values: `req_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `count`=0, `full`=0, `err`=0, `done`=0.
- Latency: accept at edge N → `mem_we` high during cycle N+1, one write per cycle. Sustained throughput is 1 instruction/cycle.
- `req_ready` is registered-state-derived only, with no combinational path from `req_valid`. `finish` is the exception: it gates ready combinationally in the same cycle.
- `err` rises in the cycle after the rejected accept.
- `done` rises the cycle after entering DONE (registered state).
- Reset mid-write: `mem_we` is 0 in the cycle after `rst`; the pending word is lost.

## Structure
- Shared package `control_pkg`:
  - opcode constants (OP_LOAD 0000011, OP_STORE 0100011, OP_RTYPE 0110011, OP_BRANCH 1100011);
  - `req_kind_t` enum;
  - loader state enum.
  
  The main decoder's case labels will be migrated to the same opcode constants.
- Sub-module `instr_encoder`: combinational. Inputs are kind, regs, funct3, funct7b5 and imm; outputs are `word` and `legal`. It is instantiated once in `instr_mem_loader`, which owns the FSM, ptr, count and the write stage register.

## Test plan
- start with base_addr=0x00, lw rd=5 rs1=2 imm=8 → write addr 0x00 data 0x00812283, count=1.
- Back-to-back sw rs2=5 rs1=2 imm=12, add rd=3 rs1=1 rs2=2, sub (funct7b5=1) → data 0x00512623, 0x002081B3, 0x402081B3 at 0x04/0x08/0x0C on consecutive cycles.
- beq rs1=1 rs2=2 imm=-4 → 0xFE208EE3. Then beq imm=3 → no write, err=1, count unchanged.
- base_addr=0xF8, three requests → writes at 0xF8, 0xFC; full=1 after second; third not accepted (req_ready=0), no wrap to 0x00.
- finish in same cycle as the final accept's write → DRAIN, then done=1. Next start clears done/err/count and re-arms at new base.
- rst asserted the cycle after an accept → mem_we=0, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/control_pkg.sv
// Shared control definitions for the instruction-memory writer and the CPU
// decoders: RV32I opcode constants, request kinds and loader FSM states.
// No ports (package).
package control_pkg;

    localparam int OP_WIDTH = 7;

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_LW    = 2'b00,
        KIND_SW    = 2'b01,
        KIND_RTYPE = 2'b10,
        KIND_BEQ   = 2'b11
    } req_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } loader_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: turns one symbolic request into an RV32I word and
// flags whether the request can be represented legally.
//   kind_i      request kind (lw / sw / R-type / beq)
//   rd_i, rs1_i, rs2_i  register indices
//   funct3_i, funct7b5_i  R-type function fields
//   imm_i       13-bit signed immediate
//   word_o      encoded instruction
//   legal_o     1 when the request is encodable
module instr_encoder
    import control_pkg::*;
(
    input  req_kind_t   kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        unique case (kind_i)
            KIND_LW: begin
                word_o  = {imm_i[11:0], rs1_i, 3'b010, rd_i, OP_LOAD};
                // 12-bit I-immediate: bit 12 must be a pure sign extension
                legal_o = (imm_i[12] == imm_i[11]);
            end
            KIND_SW: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OP_STORE};
                legal_o = (imm_i[12] == imm_i[11]);
            end
            KIND_RTYPE: begin
                word_o  = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
                // only sub and sra carry funct7 bit 5
                legal_o = !funct7b5_i || (funct3_i == 3'b000) || (funct3_i == 3'b101);
            end
            KIND_BEQ: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                legal_o = (imm_i[0] == 1'b0);
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Sequential instruction-memory writer. Accepts symbolic requests over a
// valid/ready handshake, encodes them and writes one word per cycle upward
// from base_addr_i through a registered write port.
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, finish_i     arm at base_addr_i / end of program
//   base_addr_i           first byte address (low two bits ignored)
//   req_*_i, req_ready_o  request handshake and fields
//   mem_we_o, mem_addr_o, mem_wdata_o  instruction memory write port
//   count_o, full_o, err_o, done_o     status
module instr_mem_loader
    import control_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  finish_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_kind_i,
    input  logic [4:0]            req_rd_i,
    input  logic [4:0]            req_rs1_i,
    input  logic [4:0]            req_rs2_i,
    input  logic [2:0]            req_funct3_i,
    input  logic                  req_funct7b5_i,
    input  logic [12:0]           req_imm_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH-2:0] count_o,
    output logic                  full_o,
    output logic                  err_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-2:0] count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    instr_encoder u_encoder (
        .kind_i     (req_kind_t'(req_kind_i)),
        .rd_i       (req_rd_i),
        .rs1_i      (req_rs1_i),
        .rs2_i      (req_rs2_i),
        .funct3_i   (req_funct3_i),
        .funct7b5_i (req_funct7b5_i),
        .imm_i      (req_imm_i),
        .word_o     (enc_word),
        .legal_o    (enc_legal)
    );

    // finish and start are the only same-cycle inputs allowed to gate ready;
    // a start cycle re-arms the loader, so a request offered then is not taken.
    assign req_ready_o = (state_q == ST_LOAD) && !full_q && !finish_i && !start_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (start_i) begin
            state_d = ST_LOAD;
            ptr_d   = base_addr_i & WORD_MASK;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (finish_i) begin
                        state_d = we_q ? ST_DRAIN : ST_DONE;
                    end else if (accept) begin
                        if (enc_legal) begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = DATA_WIDTH'(enc_word);
                            count_d = count_q + (ADDR_WIDTH-1)'(1);
                            // stop at the top of memory instead of wrapping
                            if (ptr_q == LAST_ADDR) begin
                                full_d = 1'b1;
                            end else begin
                                ptr_d = ptr_q + ADDR_WIDTH'(4);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_DRAIN: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign err_o       = err_q;
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_funct7b5 = 1'b0;
    logic [12:0] req_imm = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic        full, err, done;

    instr_mem_loader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .finish_i       (finish),
        .base_addr_i    (base_addr),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_kind_i     (req_kind),
        .req_rd_i       (req_rd),
        .req_rs1_i      (req_rs1),
        .req_rs2_i      (req_rs2),
        .req_funct3_i   (req_funct3),
        .req_funct7b5_i (req_funct7b5),
        .req_imm_i      (req_imm),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .count_o        (count),
        .full_o         (full),
        .err_o          (err),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_DONE = 3;

    function automatic void encode(input int kind, input int rd, input int rs1, input int rs2,
                                   input int f3, input int f7, input int imm,
                                   output bit [31:0] word, output bit legal);
        bit [31:0] u;
        u = imm;
        case (kind)
            0: begin
                legal = (imm >= -2048) && (imm <= 2047);
                word  = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            end
            1: begin
                legal = (imm >= -2048) && (imm <= 2047);
                word  = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
            end
            2: begin
                legal = (f7 == 0) || (f3 == 0) || (f3 == 5);
                word  = (f7 != 0 ? 32'h4000_0000 : 32'h0) | (rs2 << 20) | (rs1 << 15)
                      | (f3 << 12) | (rd << 7) | 32'h33;
            end
            default: begin
                legal = (imm % 2) == 0;
                word  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            end
        endcase
    endfunction

    int        m_mode = M_IDLE;
    int        m_ptr = 0, m_count = 0;
    bit        m_full = 0, m_err = 0, m_we = 0;
    bit [31:0] m_addr = 0, m_wdata = 0;

    always @(posedge clk) begin
        bit [31:0] w;
        bit        lg;
        bit        rdy;
        bit        nwe;
        if (rst) begin
            m_mode = M_IDLE; m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_wdata = 0;
        end else if (start) begin
            m_mode = M_LOAD; m_ptr = int'(base_addr) & ~3; m_count = 0;
            m_full = 0; m_err = 0; m_we = 0;
        end else begin
            rdy = (m_mode == M_LOAD) && !m_full && !finish;
            nwe = 0;
            if (m_mode == M_LOAD && finish) m_mode = m_we ? M_DRAIN : M_DONE;
            else if (m_mode == M_DRAIN) m_mode = M_DONE;
            if (rdy && req_valid) begin
                encode(int'(req_kind), int'(req_rd), int'(req_rs1), int'(req_rs2),
                       int'(req_funct3), int'(req_funct7b5), int'($signed(req_imm)), w, lg);
                if (lg) begin
                    nwe = 1; m_addr = m_ptr; m_wdata = w; m_count++;
                    if (m_ptr == 252) m_full = 1;
                    else m_ptr += 4;
                end else m_err = 1;
            end
            m_we = nwe;
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    int        cyc = 0;
    bit [7:0]  log_addr[$];
    bit [31:0] log_data[$];
    int        log_cyc[$];

    always @(negedge clk) begin
        cyc++;
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
            chk("mem_addr", 32'(mem_addr), m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_full));
        chk("err", 32'(err), 32'(m_err));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("req_ready", 32'(req_ready),
            32'((m_mode == M_LOAD) && !m_full && !finish && !start));
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input int kind, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input int imm);
        req_kind     = kind[1:0];
        req_rd       = rd[4:0];
        req_rs1      = rs1[4:0];
        req_rs2      = rs2[4:0];
        req_funct3   = f3[2:0];
        req_funct7b5 = f7[0];
        req_imm      = imm[12:0];
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit [31:0] w;
        bit        lg;
        bit [7:0]  exp_a[9];
        bit [31:0] exp_d[9];

        // pin the model's encoder against hand-computed words
        encode(0, 5, 2, 0, 0, 0, 8, w, lg);  chk("model_lw", w, 32'h00812283);
        encode(1, 0, 2, 5, 0, 0, 12, w, lg); chk("model_sw", w, 32'h00512623);
        encode(3, 0, 1, 2, 0, 0, -4, w, lg); chk("model_beq", w, 32'hFE208EE3);
        encode(3, 0, 1, 2, 0, 0, 3, w, lg);  chk("model_beq_illegal", 32'(lg), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", 32'(req_ready), 0);
        #1;

        // program at base 0: back-to-back legal requests, then illegal ones
        do_start(8'h00);
        req(0, 5, 2, 0, 0, 0, 8);
        req(1, 0, 2, 5, 0, 0, 12);
        req(2, 3, 1, 2, 0, 0, 0);
        req(2, 3, 1, 2, 0, 1, 0);
        req(3, 0, 1, 2, 0, 0, -4);
        req(3, 0, 1, 2, 0, 0, 3);
        req(0, 1, 1, 0, 0, 0, 2048);
        req(2, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        chk("seg1_err", 32'(err), 1);
        chk("seg1_count", 32'(count), 5);
        #1;

        // near the top of memory; low address bits must be ignored
        do_start(8'hFB);
        req(0, 1, 1, 0, 0, 0, 0);
        req(1, 0, 4, 3, 0, 0, -8);
        req_kind = 2'b10; req_rd = 5'd2; req_rs1 = 5'd2; req_rs2 = 5'd2;
        req_funct3 = 3'd0; req_funct7b5 = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        chk("seg2_full", 32'(full), 1);
        chk("seg2_count", 32'(count), 2);
        chk("seg2_ready_when_full", 32'(req_ready), 0);
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0;
        @(negedge clk);
        chk("seg2_done", 32'(done), 1);
        #1;

        // illegal request, one write, finish during that write -> DRAIN
        do_start(8'h10);
        req(3, 0, 1, 1, 0, 0, 1);
        req(0, 1, 0, 0, 0, 0, 4);
        finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0;
        @(negedge clk);
        chk("drain_not_done", 32'(done), 0);
        @(negedge clk);
        chk("drain_then_done", 32'(done), 1);
        chk("seg3_err", 32'(err), 1);
        #1;

        // restart clears status; reset right after an accept
        do_start(8'h20);
        @(negedge clk);
        chk("restart_done", 32'(done), 0);
        chk("restart_err", 32'(err), 0);
        chk("restart_count", 32'(count), 0);
        #1;
        req(0, 7, 3, 0, 0, 0, -1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_we", 32'(mem_we), 0);
        chk("post_rst_addr", 32'(mem_addr), 0);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);

        exp_a = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hF8, 8'hFC, 8'h10, 8'h20};
        exp_d = '{32'h00812283, 32'h00512623, 32'h002081B3, 32'h402081B3, 32'hFE208EE3,
                  32'h0000A083, 32'hFE322C23, 32'h00402083, 32'hFFF1A383};
        chk("write_log_len", 32'(log_addr.size()), 9);
        if (log_addr.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("log_addr[%0d]", i), 32'(log_addr[i]), 32'(exp_a[i]));
                chk($sformatf("log_data[%0d]", i), log_data[i], exp_d[i]);
            end
            for (int i = 1; i < 4; i++)
                chk($sformatf("back_to_back[%0d]", i), 32'(log_cyc[i] - log_cyc[i-1]), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
